// File: rtl/prog_loader_if.sv
// Byte-stream input and instruction-memory write bus of the program loader.
// The slave view belongs to the loader; the master view belongs to whoever
// feeds the stream and observes the memory writes.
interface prog_loader_if #(
    parameter int ADDR_W = 16
);
    logic [7:0]        in_data;
    logic              in_valid;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [15:0]       imem_wdata;

    modport master (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

    modport slave (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );
endinterface

// File: rtl/prog_loader.sv
// Program loader and run controller for the 16-bit core.
// Parses a length-prefixed byte stream into instruction-memory writes while the
// core is held in reset, keeps reset asserted for HOLD_CYCLES after loading,
// then lets the core run until a halt encoding reaches decode. From the halted
// state the next stream byte starts a new load.
module prog_loader #(
    parameter int                ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] BASE_ADDR   = 16'h0000,
    parameter int                HOLD_CYCLES = 4,
    parameter logic [15:0]       HALT_A      = 16'hE000,
    parameter logic [15:0]       HALT_B      = 16'hE7FF
) (
    input  logic               clk,
    input  logic               reset,
    prog_loader_if.slave       bus,
    input  logic [15:0]        core_instr,
    output logic               core_reset,
    output logic               load_done,
    output logic               halted
);

    typedef enum logic [2:0] {
        S_HDR_HI,
        S_HDR_LO,
        S_DATA_HI,
        S_DATA_LO,
        S_HOLD,
        S_RUN,
        S_HALTED
    } state_t;

    state_t            state_q, state_d;

    logic [15:0]       n_q, n_d;          // program length in words
    logic [15:0]       k_q, k_d;          // words written so far
    logic [7:0]        hi_q, hi_d;        // pending high byte of a word
    logic [7:0]        cnt_q, cnt_d;      // drain counter while in HOLD
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              crst_q, crst_d;
    logic              done_q, done_d;
    logic              halt_q, halt_d;

    logic              accept;
    logic              halt_hit;
    logic              drain_end;

    assign accept    = bus.in_valid & in_ready_q;
    assign halt_hit  = (core_instr == HALT_A) || (core_instr == HALT_B);
    assign drain_end = (cnt_q == 8'(HOLD_CYCLES - 1));

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= S_HDR_HI;
        else       state_q <= state_d;
    end

    // Next-state decode: advance on accepted bytes, drain expiry or halt
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_HDR_HI:  if (accept) state_d = S_HDR_LO;
            S_HDR_LO:  if (accept) state_d = ({n_q[15:8], bus.in_data} == 16'd0) ? S_HOLD : S_DATA_HI;
            S_DATA_HI: if (accept) state_d = S_DATA_LO;
            S_DATA_LO: if (accept) state_d = (k_q == n_q - 16'd1) ? S_HOLD : S_DATA_HI;
            S_HOLD:    if (drain_end) state_d = S_RUN;
            S_RUN:     if (halt_hit) state_d = S_HALTED;
            S_HALTED:  if (accept) state_d = S_HDR_LO;
            default:   state_d = S_HDR_HI;
        endcase
    end

    // Output and datapath next values; every output is registered below
    always_comb begin
        n_d     = n_q;
        k_d     = k_q;
        hi_d    = hi_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        crst_d  = crst_q;
        done_d  = done_q;
        halt_d  = halt_q;
        case (state_q)
            S_HDR_HI:  if (accept) n_d[15:8] = bus.in_data;
            S_HDR_LO: begin
                if (accept) begin
                    n_d[7:0] = bus.in_data;
                    k_d      = 16'd0;
                    cnt_d    = 8'd0;
                end
            end
            S_DATA_HI: if (accept) hi_d = bus.in_data;
            S_DATA_LO: begin
                if (accept) begin
                    we_d    = 1'b1;
                    addr_d  = BASE_ADDR + ADDR_W'(k_q);
                    wdata_d = {hi_q, bus.in_data};
                    k_d     = k_q + 16'd1;
                    cnt_d   = 8'd0;
                end
            end
            S_HOLD: begin
                if (drain_end) begin
                    crst_d = 1'b0;
                    done_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            S_RUN: if (halt_hit) halt_d = 1'b1;
            S_HALTED: begin
                // First header byte of the next program re-arms the core reset
                if (accept) begin
                    crst_d    = 1'b1;
                    done_d    = 1'b0;
                    halt_d    = 1'b0;
                    n_d[15:8] = bus.in_data;
                end
            end
            default: ;
        endcase
        in_ready_d = (state_d != S_HOLD) && (state_d != S_RUN);
    end

    // Registered outputs and datapath, all cleared by the async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            n_q        <= 16'd0;
            k_q        <= 16'd0;
            hi_q       <= 8'd0;
            cnt_q      <= 8'd0;
            in_ready_q <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= BASE_ADDR;
            wdata_q    <= 16'd0;
            crst_q     <= 1'b1;
            done_q     <= 1'b0;
            halt_q     <= 1'b0;
        end else begin
            n_q        <= n_d;
            k_q        <= k_d;
            hi_q       <= hi_d;
            cnt_q      <= cnt_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            crst_q     <= crst_d;
            done_q     <= done_d;
            halt_q     <= halt_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign core_reset     = crst_q;
    assign load_done      = done_q;
    assign halted         = halt_q;

endmodule
